// File: rtl/div_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
package div_pkg;

  localparam int REG_BUS        = 32;
  localparam int DOUBLE_REG_BUS = 64;
  localparam logic [5:0] DIV_ITERS = 6'd32;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

  // Two's-complement negate when en is set; wraps modulo 2^32.
  function automatic logic [REG_BUS-1:0] cond_neg(input logic [REG_BUS-1:0] v, input logic en);
    return en ? (~v + {{(REG_BUS-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/div.sv
// Multi-cycle 32-bit DIV/DIVU unit: one quotient bit per cycle, start/ready/annul handshake.
module div
  import div_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      signed_div_i,
  input  logic [REG_BUS-1:0]        opdata1_i,
  input  logic [REG_BUS-1:0]        opdata2_i,
  input  logic                      start_i,
  input  logic                      annul_i,
  output logic [DOUBLE_REG_BUS-1:0] result_o,
  output logic                      ready_o
);

  div_state_t                state_reg, state_next;
  logic [5:0]                cnt_reg, cnt_next;
  logic [64:0]               sr_reg, sr_next;
  logic [REG_BUS-1:0]        divisor_reg, divisor_next;
  logic                      neg_quot_reg, neg_quot_next;
  logic                      neg_rem_reg, neg_rem_next;
  logic [DOUBLE_REG_BUS-1:0] result_reg, result_next;
  logic                      ready_reg, ready_next;
  logic [32:0]               diff;

  // Trial subtraction of the divisor from the partial remainder; bit 32 is the borrow.
  assign diff = {1'b0, sr_reg[63:32]} - {1'b0, divisor_reg};

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    sr_next       = sr_reg;
    divisor_next  = divisor_reg;
    neg_quot_next = neg_quot_reg;
    neg_rem_next  = neg_rem_reg;
    result_next   = result_reg;
    ready_next    = ready_reg;
    case (state_reg)
      DIV_FREE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_next = DIV_BY_ZERO;
          end else begin
            state_next    = DIV_ON;
            cnt_next      = '0;
            divisor_next  = cond_neg(opdata2_i, signed_div_i & opdata2_i[31]);
            sr_next       = {32'b0, cond_neg(opdata1_i, signed_div_i & opdata1_i[31]), 1'b0};
            neg_quot_next = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem_next  = signed_div_i & opdata1_i[31];
          end
        end
      end
      DIV_BY_ZERO: begin
        state_next  = DIV_END;
        result_next = '0;
        ready_next  = 1'b1;
      end
      DIV_ON: begin
        if (annul_i) begin
          state_next = DIV_FREE;
          cnt_next   = '0;
        end else if (cnt_reg != DIV_ITERS) begin
          sr_next  = diff[32] ? {sr_reg[63:0], 1'b0} : {diff[31:0], sr_reg[31:0], 1'b1};
          cnt_next = cnt_reg + 6'd1;
        end else begin
          state_next  = DIV_END;
          cnt_next    = '0;
          result_next = {cond_neg(sr_reg[64:33], neg_rem_reg), cond_neg(sr_reg[31:0], neg_quot_reg)};
          ready_next  = 1'b1;
        end
      end
      DIV_END: begin
        if (!start_i) begin
          state_next  = DIV_FREE;
          result_next = '0;
          ready_next  = 1'b0;
        end
      end
      default: state_next = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= DIV_FREE;
      cnt_reg      <= '0;
      sr_reg       <= '0;
      divisor_reg  <= '0;
      neg_quot_reg <= 1'b0;
      neg_rem_reg  <= 1'b0;
      result_reg   <= '0;
      ready_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      sr_reg       <= sr_next;
      divisor_reg  <= divisor_next;
      neg_quot_reg <= neg_quot_next;
      neg_rem_reg  <= neg_rem_next;
      result_reg   <= result_next;
      ready_reg    <= ready_next;
    end
  end

  assign result_o = result_reg;
  assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the div unit.
module tb_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Counts edges until ready rises; 60 means it never rose within budget.
  task automatic wait_ready(output int n);
    n = 0;
    while (n < 60) begin
      tick();
      n++;
      if (ready) break;
    end
  endtask

  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
    int n;
    signed_div = sgn;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    wait_ready(n);
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " result"}, result, exp_res);
    tick();
    check({tag, " hold"}, {63'b0, ready}, 64'd1);
    check({tag, " held result"}, result, exp_res);
    start = 1'b0;
    tick();
    check({tag, " ready drop"}, {63'b0, ready}, 64'd0);
    check({tag, " result clear"}, result, 64'd0);
    $display("txn %s: a=%h b=%h signed=%0b result=%h latency=%0d", tag, a, b, sgn, result, n);
  endtask

  initial begin
    int n;
    #1;
    check("async reset ready", {63'b0, ready}, 64'd0);
    check("async reset result", result, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle ready", {63'b0, ready}, 64'd0);

    run_div("udiv 100/7",   1'b0, 32'd100,        32'd7,          {32'd2, 32'd14}, 34);
    run_div("sdiv -7/2",    1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD}, 34);
    run_div("sdiv 7/-2",    1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD}, 34);
    run_div("sdiv -8/-3",   1'b1, 32'hFFFFFFF8,   32'hFFFFFFFD,   {32'hFFFFFFFE, 32'd2}, 34);
    run_div("div by zero",  1'b0, 32'd5,          32'd0,          64'd0, 2);
    run_div("sdiv ovf",     1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0, 32'h80000000}, 34);
    run_div("udiv big",     1'b0, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000, 32'd0}, 34);
    run_div("udiv max/1",   1'b0, 32'hFFFFFFFF,   32'd1,          {32'd0, 32'hFFFFFFFF}, 34);
    run_div("udiv 7/100",   1'b0, 32'd7,          32'd100,        {32'd7, 32'd0}, 34);

    // start together with annul in idle must not be accepted
    signed_div = 1'b0; op1 = 32'd20; op2 = 32'd4; start = 1'b1; annul = 1'b1;
    tick();
    annul = 1'b0;
    wait_ready(n);
    check("annul-in-idle latency", 64'(n), 64'd34);
    check("annul-in-idle result", result, {32'd0, 32'd5});
    start = 1'b0;
    tick();

    // annul during iteration 10, then an immediate new start
    op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    repeat (11) tick();
    check("pre-annul ready", {63'b0, ready}, 64'd0);
    annul = 1'b1;
    tick();
    annul = 1'b0;
    check("post-annul ready", {63'b0, ready}, 64'd0);
    op1 = 32'd9; op2 = 32'd3;
    wait_ready(n);
    check("restart latency", 64'(n), 64'd34);
    check("restart result", result, {32'd0, 32'd3});
    $display("txn annul+restart 9/3: result=%h latency=%0d", result, n);
    start = 1'b0;
    tick();

    // async reset while a result is held
    op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    wait_ready(n);
    check("pre-reset ready", {63'b0, ready}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("reset in end ready", {63'b0, ready}, 64'd0);
    check("reset in end result", result, 64'd0);
    start = 1'b0;
    #2 rst = 1'b0;
    tick();

    // async reset mid-division discards the operation
    op1 = 32'd50; op2 = 32'd5; start = 1'b1;
    repeat (15) tick();
    #2 rst = 1'b1;
    #1;
    check("reset in on ready", {63'b0, ready}, 64'd0);
    check("reset in on result", result, 64'd0);
    start = 1'b0;
    #2 rst = 1'b0;
    repeat (40) tick();
    check("discarded op ready", {63'b0, ready}, 64'd0);
    run_div("post-reset 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
